// File: rtl/fetch_unit_if.sv
// fetch_unit_if: redirect, instruction-memory and decode-side handshakes of the fetch unit
interface fetch_unit_if;
  logic redirect;
  logic [31:0] redirect_pc;
  logic imem_req_valid;
  logic imem_req_ready;
  logic [31:0] imem_req_addr;
  logic imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic inst_valid;
  logic inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  modport master (
    input redirect, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
  );
  modport slave (
    output redirect, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    input imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a 2-entry {pc, word} buffer.
// Define FETCH_PIPELINE_EN to allow a new request in the cycle a response retires.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, PEND, DROP} state_t;
  state_t state, state_n;
  logic [31:0] fetch_pc;
  logic [31:0] buf_pc [2];
  logic [31:0] buf_data [2];
  logic head;
  logic [1:0] count;
  logic fire, deq, enq, room, busy_n;
  assign bus.imem_req_addr = {fetch_pc[31:2], 2'b00};
  assign fire = bus.imem_req_valid && bus.imem_req_ready;
  assign deq = bus.inst_valid && bus.inst_ready;
  assign enq = bus.imem_resp_valid && state == PEND && !bus.redirect;
  // an outstanding kept response already owns one buffer slot
  assign room = ({1'b0, count} + {2'b00, state == PEND}) < 3'd2;
  assign bus.inst_valid = count != 2'd0;
  assign bus.inst_data = buf_data[head];
  assign bus.inst_pc = buf_pc[head];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // busy_n: a request is still outstanding after this edge
  always_comb begin
    busy_n = fire || (state != IDLE && !bus.imem_resp_valid);
    state_n = !busy_n ? IDLE : bus.redirect ? DROP : fire ? PEND : state;
  end
  always_comb
`ifdef FETCH_PIPELINE_EN
    bus.imem_req_valid = rst_n && room && (state == IDLE || bus.imem_resp_valid);
`else
    bus.imem_req_valid = rst_n && room && state == IDLE;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      count <= 2'd0;
      head <= 1'b0;
      buf_pc <= '{default: '0};
      buf_data <= '{default: '0};
    end else begin
      if (bus.redirect) fetch_pc <= bus.redirect_pc & ~32'd3;
      else if (fire) fetch_pc <= fetch_pc + 32'd4;
      count <= bus.redirect ? 2'd0 : count + {1'b0, enq} - {1'b0, deq};
      if (deq) head <= ~head;
      // fetch_pc is one word past the kept request while it is outstanding
      if (enq) begin
        buf_pc[head ^ count[0]] <= bus.imem_req_addr - 32'd4;
        buf_data[head ^ count[0]] <= bus.imem_resp_data;
      end
    end
endmodule
